spi_word_slave: RTL and testbench
=================================

# spi_word_slave

Mode-3 (CPOL=1, CPHA=1) SPI slave front end running entirely in the system clock domain. It oversamples CS/SCK/MOSI, assembles 16-bit MSB-first words from the external master, and serialises 16-bit response words onto MISO. Multiple words per CS-low frame are supported for RDREG second-word readback and RDDATA bursts. It sits between the chip pins and the command decoder: it consumes what the SPI master drives and feeds decoded words downstream.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on CS, SCK and MOSI; legal values 2..3.
- `clk`  in  1  system clock; must be at least 8× the SCK frequency (≥80 MHz for 10 MHz SCK).
- `rst`  in  1  reset; synchronous, active-high.
- `CS`  in  1  chip select, active low, asynchronous to `clk`.
- `SCK`  in  1  SPI clock, idles high, asynchronous.
- `MOSI`  in  1  serial data in, asynchronous.
- `MISO`  out  1  serial data out, registered.
- `rx_data`  out  16  last completed received word.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid in this cycle. There is no backpressure.
- `tx_data`  in  16  next response word.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  TX holding register empty.
- `frame_active`  out  1  synchronised CS is low.
- `word_start`  out  1  one-cycle pulse when a word's bit 15 is launched on MISO.
- `tx_underrun`  out  1  one-cycle pulse when a word starts with no TX data available.
- `partial_drop`  out  1  one-cycle pulse when CS rises with 1..15 bits received.

## Operation
- Input sync: `SYNC_STAGES` flops, then one history flop per signal. `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise` are derived from the last two stages.
- FSM states:
  - IDLE: CS high.
  - ARMED: CS low, bit count 0.
  - SHIFT: 1..15 bits received.
- IDLE→ARMED on `cs_fall`. ARMED→SHIFT on the first `sck_rise`. SHIFT→ARMED on the 16th `sck_rise` (word complete). Any state→IDLE on `cs_rise`.
- `sck_fall` while bit count is 0 (word start):
  - Load the TX holding register: MISO = bit 15, and the shift register takes bits 14:0.
  - Pulse `word_start` and free the holding register.
- `sck_fall` otherwise: MISO ← next bit, MSB first.
- `sck_rise`: `rx_shift` ← {`rx_shift[14:0]`, `MOSI_sync`} and the 4-bit bit count increments.
  - On reaching 16: `rx_data` ← the assembled word, `rx_valid` pulses, and the bit count wraps to 0.
- Holding register:
  - Written when `tx_valid && tx_ready`.
  - If empty at word start: shift 16'h0000 and pulse `tx_underrun`.
  - Write and word-start load in the same cycle: the load consumes the old contents if full. If empty, the new `tx_data` is forwarded directly and counts as consumed (no underrun).
- `cs_rise` with bit count 1..15:
  - Discard the partial word, pulse `partial_drop`, no `rx_valid`.
  - A trailing 17th SCK cycle from the master is legal and therefore ends as a 1-bit partial drop.
- `cs_rise` with bit count 0: clean end, no pulse.
- SCK edges while CS is high are ignored. MISO is held at 0 while CS is high.
- Reset mid-frame:
  - All state cleared and FSM → IDLE.
  - The block waits for a fresh `cs_fall`, even if CS is still low when `rst` deasserts.

## Timing
- Reset values:
  - MISO 0, `rx_data` 16'h0000, `rx_valid` 0.
  - `tx_ready` 1, `frame_active` 0, `word_start` 0, `tx_underrun` 0, `partial_drop` 0.
  - Holding register empty.
- Edge detect latency: an edge is flagged `SYNC_STAGES`+1 `clk` edges after the pin transition.
- `rx_valid` is registered in the same cycle the 16th `sck_rise` is flagged.
- MISO updates one `clk` after `sck_fall` is flagged. For SYNC=2 this is ≤4 clk after the pin fall, within the SCK low half-period at the 8× ratio.
- `tx_data` for word N+1 must be written before the first SCK fall of word N+1.
  - Earliest safe point: the `rx_valid` of word N.
  - Budget: roughly one SCK half-period minus sync latency.
- `frame_active` follows the synchronised CS.

## Configuration
- `SPI_SLAVE_TXBUF_EN` defined:
  - Holding register and `tx_ready`/`tx_underrun` behave as above.
- Not defined:
  - No holding register; `tx_data` is sampled directly at word start and `tx_valid` is ignored.
  - `tx_ready` is tied to 1 and `tx_underrun` is tied to 0.

## Test plan
- Single word: CS low, master sends 16'hA5C3, TX preloaded with 16'h1234 → one `rx_valid` with `rx_data`=16'hA5C3, master receives 16'h1234, no drop or underrun.
- Burst: 4 words 16'h0001..16'h0004 in one CS frame, TX refilled on each `rx_valid` with 16'hF001..F004 → four `rx_valid` pulses in order, master reads F001..F004, four `word_start` pulses.
- Underrun (`SPI_SLAVE_TXBUF_EN` defined): no TX write before a word → master reads 16'h0000 and `tx_underrun` pulses once.
- 17th-clock trailer: 16 bits 16'h8001 plus one extra SCK cycle, then CS high → one `rx_valid` (16'h8001) and one `partial_drop`.
- Reset mid-word: assert `rst` after 7 bits, release with CS still low, continue clocking → no `rx_valid` until CS cycles high→low. After that, a new 16'h5A5A is received correctly; all outputs are at reset values during `rst`.
- Same-cycle write/load: `tx_valid` with holding empty, coincident with a word-start fall → the word carries the new `tx_data`, no underrun, `tx_ready` 1 afterwards.

Source files
------------

// File: rtl/spi_word_slave.sv
// rtl/spi_word_slave.sv - Mode-3 SPI 16-bit word slave; TX holding register enabled by SPI_SLAVE_TXBUF_EN
module spi_word_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        frame_active,
    output logic        word_start,
    output logic        tx_underrun,
    output logic        partial_drop
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sr, sck_sr, mosi_sr;
    logic                   cs_h, sck_h;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise, sck_fall, sck_rise;
    logic [1:0]             state;
    logic [3:0]             bit_cnt;
    logic [14:0]            rx_shift;
    logic [14:0]            tx_shift;
    logic                   word_load;
    logic                   load_empty;
    logic [15:0]            load_word;

    // Synchronisers carry no reset so CS held low across rst never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        cs_sr   <= {cs_sr[SYNC_STAGES-2:0], CS};
        sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
        cs_h    <= cs_sr[SYNC_STAGES-1];
        sck_h   <= sck_sr[SYNC_STAGES-1];
    end

    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign cs_fall  = ~cs_s & cs_h;
    assign cs_rise  = cs_s & ~cs_h;
    assign sck_fall = ~sck_s & sck_h;
    assign sck_rise = sck_s & ~sck_h;

    assign word_load = (state != IDLE) && !cs_rise && sck_fall && (bit_cnt == 4'd0);

`ifdef SPI_SLAVE_TXBUF_EN
    logic        hold_full;
    logic [15:0] hold_data;

    assign tx_ready = ~hold_full;

    // An empty register with a same-cycle write forwards tx_data straight into the word.
    always_comb begin
        load_word  = 16'h0000;
        load_empty = 1'b0;
        if (hold_full) begin
            load_word = hold_data;
        end else if (tx_valid) begin
            load_word = tx_data;
        end else begin
            load_empty = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= 16'h0000;
        end else if (word_load) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end
    end
`else
    logic unused_tx_valid;

    assign unused_tx_valid = tx_valid;
    assign tx_ready        = 1'b1;
    assign load_word       = tx_data;
    assign load_empty      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            rx_shift     <= 15'd0;
            tx_shift     <= 15'd0;
            rx_data      <= 16'h0000;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            frame_active <= 1'b0;
            word_start   <= 1'b0;
            tx_underrun  <= 1'b0;
            partial_drop <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            word_start   <= 1'b0;
            tx_underrun  <= 1'b0;
            partial_drop <= 1'b0;
            frame_active <= ~cs_s;
            if (cs_rise) begin
                state        <= IDLE;
                bit_cnt      <= 4'd0;
                MISO         <= 1'b0;
                partial_drop <= (bit_cnt != 4'd0);
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    state   <= ARMED;
                    bit_cnt <= 4'd0;
                end
            end else begin
                if (word_load) begin
                    MISO        <= load_word[15];
                    tx_shift    <= load_word[14:0];
                    word_start  <= 1'b1;
                    tx_underrun <= load_empty;
                end else if (sck_fall) begin
                    MISO     <= tx_shift[14];
                    tx_shift <= {tx_shift[13:0], 1'b0};
                end
                if (sck_rise) begin
                    rx_shift <= {rx_shift[13:0], mosi_s};
                    bit_cnt  <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        rx_data  <= {rx_shift, mosi_s};
                        rx_valid <= 1'b1;
                        state    <= ARMED;
                    end else begin
                        state <= SHIFT;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_word_slave.sv
// tb/tb_spi_word_slave.sv - self-checking bench for spi_word_slave (table, directed and random frames)
module tb_spi_word_slave;
    localparam int SYNC = 2;
    localparam int H    = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CS = 1'b1;
    logic        SCK = 1'b1;
    logic        MOSI = 1'b0;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        MISO, rx_valid, tx_ready, frame_active, word_start, tx_underrun, partial_drop;
    logic [15:0] rx_data;

    always #5 clk = ~clk;

    spi_word_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .frame_active(frame_active), .word_start(word_start),
        .tx_underrun(tx_underrun), .partial_drop(partial_drop)
    );

    int nchk = 0;
    int nfail = 0;

    logic [15:0] rx_log[$];
    int ws_cnt = 0, ud_cnt = 0, pd_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (word_start) ws_cnt++;
        if (tx_underrun) ud_cnt++;
        if (partial_drop) pd_cnt++;
    end

    typedef struct {
        logic [15:0] mosi;
        logic [15:0] tx;
        int          n;
        int          trail;
        int          exp_rx_cnt;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
        int          exp_drop;
    } vec_t;

    vec_t        tbl[5];
    logic [15:0] fr_mosi[4];
    logic [15:0] fr_tx[4];
    logic [15:0] fr_miso[4];
    logic [15:0] exp_m[4];
    bit          fr_skip[4];
    bit          fr_done;
    int          fr_fq;
    logic        bit_in;
    int          rx0, ws0, ud0, pd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic mo, output logic mi);
        SCK  = 1'b0;
        MOSI = mo;
        wait_clk(H);
        mi  = MISO;
        SCK = 1'b1;
        wait_clk(H);
    endtask

    task automatic tx_write(input logic [15:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic snap();
        rx0 = rx_log.size();
        ws0 = ws_cnt;
        ud0 = ud_cnt;
        pd0 = pd_cnt;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(MISO), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        check({tag, "_word_start"}, 32'(word_start), 32'd0);
        check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_partial_drop"}, 32'(partial_drop), 32'd0);
    endtask

    // One CS-low frame of n words plus trail extra bits; TX for word k>0 is offered on the rx_valid of word k-1.
    task automatic run_frame(input int n, input int trail);
        if (n > 0 && !fr_skip[0]) tx_write(fr_tx[0]);
        fr_done = 1'b0;
        fr_fq   = 1;
        fork
            begin
                CS = 1'b0;
                wait_clk(H);
                for (int k = 0; k < n; k++) begin
                    for (int b = 0; b < 16; b++) begin
                        sck_bit(fr_mosi[k][15-b], bit_in);
                        fr_miso[k][15-b] = bit_in;
                    end
                end
                for (int t = 0; t < trail; t++) sck_bit(1'($urandom_range(0, 1)), bit_in);
                wait_clk(H);
                CS = 1'b1;
                wait_clk(3 * H);
                fr_done = 1'b1;
            end
            begin
                while (!fr_done) begin
                    @(negedge clk);
                    if (tx_valid) tx_valid = 1'b0;
                    if (rx_valid && fr_fq < n) begin
                        if (!fr_skip[fr_fq]) begin
                            tx_data  = fr_tx[fr_fq];
                            tx_valid = 1'b1;
                        end
                        fr_fq++;
                    end
                end
                tx_valid = 1'b0;
            end
        join
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] prev;
        int          n, trail, nskip;

        tbl[0] = '{16'hA5C3, 16'h1234, 1, 0, 1, 16'hA5C3, 16'h1234, 0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1, 0, 1, 16'hFFFF, 16'h0000, 0};
        tbl[2] = '{16'h0000, 16'hFFFF, 1, 0, 1, 16'h0000, 16'hFFFF, 0};
        tbl[3] = '{16'h8001, 16'h4321, 1, 1, 1, 16'h8001, 16'h4321, 1};
        tbl[4] = '{16'h0000, 16'h0000, 0, 7, 0, 16'h0000, 16'h0000, 1};

        wait_clk(6);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(6);
        check("idle_frame_active", 32'(frame_active), 32'd0);

        for (int i = 0; i < 5; i++) begin
            fr_mosi[0] = tbl[i].mosi;
            fr_tx[0]   = tbl[i].tx;
            fr_skip[0] = 1'b0;
            snap();
            run_frame(tbl[i].n, tbl[i].trail);
            check($sformatf("tbl%0d_rx_cnt", i), 32'(rx_log.size() - rx0), 32'(tbl[i].exp_rx_cnt));
            if (tbl[i].exp_rx_cnt > 0 && rx_log.size() > rx0)
                check($sformatf("tbl%0d_rx_data", i), 32'(rx_log[rx0]), 32'(tbl[i].exp_rx));
            if (tbl[i].n > 0)
                check($sformatf("tbl%0d_miso_word", i), 32'(fr_miso[0]), 32'(tbl[i].exp_miso));
            check($sformatf("tbl%0d_drop", i), 32'(pd_cnt - pd0), 32'(tbl[i].exp_drop));
            check($sformatf("tbl%0d_miso_idle", i), 32'(MISO), 32'd0);
        end

        for (int k = 0; k < 4; k++) begin
            fr_mosi[k] = 16'(k + 1);
            fr_tx[k]   = 16'hF001 + 16'(k);
            fr_skip[k] = 1'b0;
        end
        snap();
        run_frame(4, 0);
        check("burst_rx_cnt", 32'(rx_log.size() - rx0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (rx0 + k < rx_log.size())
                check($sformatf("burst_rx%0d", k), 32'(rx_log[rx0+k]), 32'(k + 1));
            check($sformatf("burst_miso%0d", k), 32'(fr_miso[k]), 32'(16'hF001 + 16'(k)));
        end
        check("burst_word_start", 32'(ws_cnt - ws0), 32'd4);
        check("burst_underrun", 32'(ud_cnt - ud0), 32'd0);

`ifdef SPI_SLAVE_TXBUF_EN
        fr_mosi[0] = 16'h3C5A;
        fr_tx[0]   = 16'hDEAD;
        fr_skip[0] = 1'b1;
        snap();
        run_frame(1, 0);
        check("underrun_miso", 32'(fr_miso[0]), 32'd0);
        check("underrun_pulses", 32'(ud_cnt - ud0), 32'd1);
        check("underrun_rx", 32'(rx_log[rx_log.size()-1]), 32'h3C5A);
`endif

        for (int f = 0; f < 20; f++) begin
            n     = $urandom_range(1, 4);
            trail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            prev  = tx_data;
            nskip = 0;
            for (int k = 0; k < n; k++) begin
                fr_mosi[k] = 16'($urandom);
                fr_tx[k]   = 16'($urandom);
                fr_skip[k] = ($urandom_range(0, 4) == 0);
                if (fr_skip[k]) nskip++;
                else prev = fr_tx[k];
`ifdef SPI_SLAVE_TXBUF_EN
                exp_m[k] = fr_skip[k] ? 16'h0000 : fr_tx[k];
`else
                exp_m[k] = prev;
`endif
            end
            snap();
            run_frame(n, trail);
            check($sformatf("rnd%0d_rx_cnt", f), 32'(rx_log.size() - rx0), 32'(n));
            for (int k = 0; k < n; k++) begin
                if (rx0 + k < rx_log.size())
                    check($sformatf("rnd%0d_rx%0d", f, k), 32'(rx_log[rx0+k]), 32'(fr_mosi[k]));
                check($sformatf("rnd%0d_miso%0d", f, k), 32'(fr_miso[k]), 32'(exp_m[k]));
            end
            check($sformatf("rnd%0d_word_start", f), 32'(ws_cnt - ws0), 32'(n + (trail > 0 ? 1 : 0)));
            check($sformatf("rnd%0d_drop", f), 32'(pd_cnt - pd0), 32'(trail > 0 ? 1 : 0));
`ifdef SPI_SLAVE_TXBUF_EN
            check($sformatf("rnd%0d_underrun", f), 32'(ud_cnt - ud0), 32'(nskip + (trail > 0 ? 1 : 0)));
`else
            check($sformatf("rnd%0d_underrun", f), 32'(ud_cnt - ud0), 32'd0);
`endif
        end

        CS = 1'b0;
        wait_clk(H);
        for (int b = 0; b < 7; b++) sck_bit(1'b1, bit_in);
        rst = 1'b1;
        wait_clk(3);
        check_reset_outputs("midrst");
        rst = 1'b0;
        snap();
        wait_clk(H);
        for (int b = 0; b < 25; b++) sck_bit(1'($urandom_range(0, 1)), bit_in);
        check("midrst_no_rx", 32'(rx_log.size() - rx0), 32'd0);
        CS = 1'b1;
        wait_clk(3 * H);
        check("midrst_no_drop", 32'(pd_cnt - pd0), 32'd0);
        fr_mosi[0] = 16'h5A5A;
        fr_tx[0]   = 16'h0F0F;
        fr_skip[0] = 1'b0;
        snap();
        run_frame(1, 0);
        check("midrst_rx_cnt", 32'(rx_log.size() - rx0), 32'd1);
        check("midrst_rx_data", 32'(rx_log[rx_log.size()-1]), 32'h5A5A);
        check("midrst_miso", 32'(fr_miso[0]), 32'h0F0F);

        // tx_valid is raised so the write lands on the very clock that loads bit 15
        snap();
        fr_mosi[0] = 16'h3C3C;
        CS = 1'b0;
        wait_clk(H);
        check("samecyc_frame_active", 32'(frame_active), 32'd1);
        tx_data = 16'hC0DE;
        SCK     = 1'b0;
        MOSI    = fr_mosi[0][15];
        wait_clk(SYNC);
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("samecyc_word_start", 32'(word_start), 32'd1);
        check("samecyc_no_underrun", 32'(tx_underrun), 32'd0);
        wait_clk(H - SYNC - 1);
        fr_miso[0][15] = MISO;
        SCK = 1'b1;
        wait_clk(H);
        for (int b = 1; b < 16; b++) begin
            sck_bit(fr_mosi[0][15-b], bit_in);
            fr_miso[0][15-b] = bit_in;
        end
        wait_clk(H);
        CS = 1'b1;
        wait_clk(3 * H);
        check("samecyc_miso", 32'(fr_miso[0]), 32'hC0DE);
        check("samecyc_rx", 32'(rx_log[rx_log.size()-1]), 32'h3C3C);
        check("samecyc_underrun_total", 32'(ud_cnt - ud0), 32'd0);
        check("samecyc_tx_ready", 32'(tx_ready), 32'd1);
        check("samecyc_frame_end", 32'(frame_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
